// File: rtl/mem_access_arb.sv
// Two-requester round-robin arbiter that serialises single-DWORD reads and writes
// onto the shared register/BRAM access port, returning read data to its owner.
module mem_access_arb #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 14
) (
  input  logic              pcie_clk,
  input  logic              pcie_rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [3:0]        a_be,
  input  logic [31:0]       a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [31:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [3:0]        b_be,
  input  logic [31:0]       b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [31:0]       b_rdata,
  output logic [3:0]        rd_be,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              wr_en,
  output logic [7:0]        wr_be,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_busy,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WR, RD, RSP} state_e;

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_e            state_q;
  logic              rr_q;      // 0: A has priority on a tie, 1: B
  logic              own_q;     // 0: A owns the transaction in flight, 1: B
  logic [2:0]        cnt_q;
  logic              a_gnt_q, b_gnt_q, a_rvalid_q, b_rvalid_q, wr_en_q, busy_q;
  logic [31:0]       a_rdata_q, b_rdata_q, wr_data_q;
  logic [ADDR_W-1:0] rd_addr_q, wr_addr_q;
  logic [3:0]        rd_be_q;
  logic [7:0]        wr_be_q;

  logic              any_req, win_b, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_be;
  logic [31:0]       sel_wdata;

  always_comb begin
    any_req   = a_req | b_req;
    win_b     = b_req & (~a_req | rr_q);
    sel_we    = win_b ? b_we    : a_we;
    sel_addr  = win_b ? b_addr  : a_addr;
    sel_be    = win_b ? b_be    : a_be;
    sel_wdata = win_b ? b_wdata : a_wdata;
  end

  // NOTE: state and outputs use non-blocking assignments so every register
  // samples pre-edge values; pulses default to 0 first, then the state decides.
  always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
    if (!pcie_rst_n) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      own_q      <= 1'b0;
      cnt_q      <= '0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      rd_be_q    <= '0;
      wr_be_q    <= '0;
    end else begin
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!wr_busy && any_req) begin
            own_q   <= win_b;
            rr_q    <= ~win_b;
            a_gnt_q <= ~win_b;
            b_gnt_q <= win_b;
            busy_q  <= 1'b1;
            if (sel_we) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= sel_addr;
              wr_be_q   <= {4'b0000, sel_be};
              wr_data_q <= sel_wdata;
              state_q   <= WR;
            end else begin
              rd_addr_q <= sel_addr;
              rd_be_q   <= sel_be;
              cnt_q     <= '0;
              state_q   <= RD;
            end
          end
        end
        WR: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        RD: begin
          // rd_addr stays put until the port has had RD_LAT cycles to answer
          if (cnt_q == RD_LAT_C) begin
            if (own_q) b_rdata_q <= rd_data;
            else       a_rdata_q <= rd_data;
            a_rvalid_q <= ~own_q;
            b_rvalid_q <= own_q;
            state_q    <= RSP;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        RSP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign a_gnt    = a_gnt_q;
  assign b_gnt    = b_gnt_q;
  assign a_rvalid = a_rvalid_q;
  assign b_rvalid = b_rvalid_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign rd_addr  = rd_addr_q;
  assign rd_be    = rd_be_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_be    = wr_be_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_access_arb.sv
// Scoreboard bench for mem_access_arb: a memory model on the access port,
// per-requester drivers, and queued expectations checked as outputs appear.
module tb_mem_access_arb;

  localparam int RD_LAT = 1;
  localparam int ADDR_W = 14;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       data;
  } txn_t;

  logic              pcie_clk, pcie_rst_n;
  logic              a_req, a_we, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [3:0]        a_be;
  logic [31:0]       a_wdata, a_rdata;
  logic              b_req, b_we, b_gnt, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [3:0]        b_be;
  logic [31:0]       b_wdata, b_rdata;
  logic [3:0]        rd_be;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [31:0]       rd_data, wr_data;
  logic              wr_en, wr_busy, busy;
  logic [7:0]        wr_be;

  mem_access_arb #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
    .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_be(a_be), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_be(b_be), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .rd_be(rd_be), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_busy(wr_busy), .busy(busy)
  );

  initial begin
    pcie_clk = 1'b0;
    forever #5 pcie_clk = ~pcie_clk;
  end

  // Read-only memory contents; reads never target addresses the bench writes.
  function automatic logic [31:0] mem_val(input logic [ADDR_W-1:0] addr);
    if (addr == 14'h2003) return 32'hDEADBEEF;
    return {2'b10, addr, 2'b01, ~addr};
  endfunction

  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge pcie_clk) begin
    rd_pipe[0] <= mem_val(rd_addr);
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rd_data = rd_pipe[RD_LAT-1];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rv_count;
  txn_t        a_pend[$], b_pend[$], exp_wr[$];
  logic [31:0] exp_rd_a[$], exp_rd_b[$];
  bit          grant_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic record(input logic who, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [3:0] be, input logic [31:0] data);
    grant_log.push_back(who);
    if (we)       exp_wr.push_back(txn_t'{we, addr, be, data});
    else if (who) exp_rd_b.push_back(mem_val(addr));
    else          exp_rd_a.push_back(mem_val(addr));
  endtask

  task automatic monitor();
    txn_t t;
    if (a_gnt || b_gnt) check("gnt_one", 32'(a_gnt & b_gnt), 0);
    if (a_gnt) record(1'b0, a_we, a_addr, a_be, a_wdata);
    if (b_gnt) record(1'b1, b_we, b_addr, b_be, b_wdata);
    if (wr_en) begin
      check("wr_with_gnt", 32'(a_gnt | b_gnt), 1);
      if (exp_wr.size() == 0) check("wr_unexp", 1, 0);
      else begin
        t = exp_wr.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(t.addr));
        check("wr_be",   32'(wr_be),   {28'h0, t.be});
        check("wr_data", wr_data,      t.data);
      end
    end
    if (a_rvalid) begin
      rv_count++;
      check("rv_one", 32'(b_rvalid), 0);
      if (exp_rd_a.size() == 0) check("a_rv_unexp", 1, 0);
      else check("a_rdata", a_rdata, exp_rd_a.pop_front());
    end
    if (b_rvalid) begin
      rv_count++;
      if (exp_rd_b.size() == 0) check("b_rv_unexp", 1, 0);
      else check("b_rdata", b_rdata, exp_rd_b.pop_front());
    end
  endtask

  task automatic drive();
    txn_t t;
    if (!pcie_rst_n) begin
      a_req = 1'b0;
      b_req = 1'b0;
      exp_wr.delete();
      exp_rd_a.delete();
      exp_rd_b.delete();
      return;
    end
    if ((a_req && a_gnt) || (!a_req && a_pend.size() > 0)) begin
      if (a_pend.size() > 0) begin
        t = a_pend.pop_front();
        a_req = 1'b1; a_we = t.we; a_addr = t.addr; a_be = t.be; a_wdata = t.data;
      end else a_req = 1'b0;
    end
    if ((b_req && b_gnt) || (!b_req && b_pend.size() > 0)) begin
      if (b_pend.size() > 0) begin
        t = b_pend.pop_front();
        b_req = 1'b1; b_we = t.we; b_addr = t.addr; b_be = t.be; b_wdata = t.data;
      end else b_req = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge pcie_clk);
    monitor();
    drive();
  endtask

  function automatic bit idle_now();
    return a_pend.size() == 0 && b_pend.size() == 0 && !a_req && !b_req && !busy &&
           exp_wr.size() == 0 && exp_rd_a.size() == 0 && exp_rd_b.size() == 0;
  endfunction

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!idle_now() && n < bound);
    if (!idle_now()) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"},     32'({a_gnt, b_gnt, a_rvalid, b_rvalid, wr_en, busy}), 0);
    check({tag, "_a_rdata"}, a_rdata, 0);
    check({tag, "_b_rdata"}, b_rdata, 0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 0);
    check({tag, "_rd_be"},   32'(rd_be), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check({tag, "_wr_be"},   32'(wr_be), 0);
    check({tag, "_wr_data"}, wr_data, 0);
  endtask

  initial begin
    pcie_rst_n = 1'b0;
    wr_busy = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_be = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_be = '0; b_wdata = '0;
    rv_count = 0;

    // Reset values
    repeat (3) step();
    check_quiet("in_rst");
    pcie_rst_n = 1'b1;
    step();
    check_quiet("post_rst");

    // Single write from A
    a_pend.push_back(txn_t'{1'b1, 14'h1005, 4'hF, 32'hC0A80A03});
    step();
    step();
    check("wr1_a_gnt",   32'(a_gnt), 1);
    check("wr1_b_gnt",   32'(b_gnt), 0);
    check("wr1_wr_en",   32'(wr_en), 1);
    check("wr1_wr_be",   32'(wr_be), 32'h0F);
    check("wr1_wr_addr", 32'(wr_addr), 32'h1005);
    step();
    check("wr1_busy", 32'(busy), 0);

    // Single read from B, RD_LAT=1
    b_pend.push_back(txn_t'{1'b0, 14'h2003, 4'hF, 32'h0});
    step();
    step();
    check("rd1_b_gnt",    32'(b_gnt), 1);
    check("rd1_addr_t1",  32'(rd_addr), 32'h2003);
    check("rd1_wr_en_t1", 32'(wr_en), 0);
    step();
    check("rd1_addr_t2",  32'(rd_addr), 32'h2003);
    check("rd1_rv_t2",    32'(b_rvalid), 0);
    step();
    check("rd1_b_rvalid", 32'(b_rvalid), 1);
    check("rd1_b_rdata",  b_rdata, 32'hDEADBEEF);
    check("rd1_a_rvalid", 32'(a_rvalid), 0);
    wait_idle(20, "rd1");

    // Contention: both hold req continuously, grants alternate starting with A
    grant_log.delete();
    a_pend.push_back(txn_t'{1'b1, 14'h1010, 4'h3, 32'h11112222});
    a_pend.push_back(txn_t'{1'b0, 14'h0020, 4'hF, 32'h0});
    a_pend.push_back(txn_t'{1'b1, 14'h1011, 4'hC, 32'h33334444});
    a_pend.push_back(txn_t'{1'b0, 14'h2021, 4'h1, 32'h0});
    b_pend.push_back(txn_t'{1'b0, 14'h0030, 4'hF, 32'h0});
    b_pend.push_back(txn_t'{1'b1, 14'h1031, 4'hF, 32'h55556666});
    b_pend.push_back(txn_t'{1'b0, 14'h2032, 4'h8, 32'h0});
    b_pend.push_back(txn_t'{1'b1, 14'h1033, 4'h6, 32'h77778888});
    wait_idle(200, "rr");
    check("rr_count", 32'(grant_log.size()), 8);
    for (int i = 0; i < grant_log.size(); i++) check("rr_order", 32'(grant_log[i]), 32'(i % 2));

    // wr_busy holds off the grant
    wr_busy = 1'b1;
    a_pend.push_back(txn_t'{1'b1, 14'h1040, 4'hF, 32'hA5A5A5A5});
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check("busy_no_gnt", 32'(a_gnt), 0);
    end
    wr_busy = 1'b0;
    step();
    check("busy_gnt", 32'(a_gnt), 1);
    wait_idle(20, "busy");

    // Reset in the middle of a read: the read is dropped, rr returns to A
    b_pend.push_back(txn_t'{1'b0, 14'h2050, 4'hF, 32'h0});
    step();
    step();
    check("mid_rd_gnt", 32'(b_gnt), 1);
    pcie_rst_n = 1'b0;
    step();
    step();
    check_quiet("mid_rst");
    pcie_rst_n = 1'b1;
    rv_count = 0;
    repeat (10) step();
    check("mid_no_rvalid", 32'(rv_count), 0);
    check("mid_busy", 32'(busy), 0);
    grant_log.delete();
    b_pend.push_back(txn_t'{1'b0, 14'h0060, 4'hF, 32'h0});
    a_pend.push_back(txn_t'{1'b1, 14'h1061, 4'hF, 32'h12345678});
    wait_idle(50, "post_mid");
    check("post_mid_count", 32'(grant_log.size()), 2);
    if (grant_log.size() > 0) check("post_mid_first_a", 32'(grant_log[0]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
